// File: rtl/ysyx_22040931_lsu_if.sv
// Memory bus between the load/store unit (master) and the data memory (slave).
// One request at a time; a response pulse acknowledges writes and carries read data.
interface ysyx_22040931_lsu_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic                  bus_req_valid;
  logic                  bus_req_ready;
  logic                  bus_req_wr;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wstrb;
  logic                  bus_rsp_valid;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    output bus_req_valid, bus_req_wr, bus_addr, bus_wdata, bus_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_wr, bus_addr, bus_wdata, bus_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/ysyx_22040931_lsu.sv
// Multi-cycle load/store unit for the memory stage: lane alignment, write strobes,
// bus handshake, load extension and pass-through of non-memory instructions.
module ysyx_22040931_lsu #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_w_ena,
  input  logic [REG_W-1:0]   in_w_addr,
  input  logic [DATA_W-1:0]  in_w_data,
  input  logic               in_mem_ena,
  input  logic               in_mem_wr,
  input  logic [2:0]         in_mem_op,
  input  logic [ADDR_W-1:0]  in_mem_addr,
  input  logic [DATA_W-1:0]  in_stor_data,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [31:0]        in_instr,
  ysyx_22040931_lsu_if.master bus,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_w_ena,
  output logic [REG_W-1:0]   out_w_addr,
  output logic [DATA_W-1:0]  out_w_data,
  output logic               out_exc,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [31:0]        out_instr
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, next_state;

  logic                accept;
  logic                fault;
  logic                mem_go;
  logic [OFF_W-1:0]    in_off;
  logic [DATA_W-1:0]   st_mask;
  logic [STRB_W-1:0]   strb_base;
  logic [DATA_W-1:0]   st_data_sh;
  logic [STRB_W-1:0]   st_strb_sh;

  logic                req_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [1:0]          ld_size;
  logic                ld_uns;
  logic [OFF_W-1:0]    ld_off;

  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   ld_mask;
  logic                ld_sbit;
  logic [DATA_W-1:0]   ld_val;

  assign accept = in_valid & in_ready;
  assign in_off = in_mem_addr[OFF_W-1:0];
  assign mem_go = in_mem_ena & ~fault;

  // Size decode: alignment fault, store byte mask and base strobe pattern
  always_comb begin
    fault     = 1'b0;
    st_mask   = '1;
    strb_base = '1;
    case (in_mem_op[1:0])
      2'd0: begin
        st_mask   = DATA_W'(64'hFF);
        strb_base = STRB_W'(8'h01);
      end
      2'd1: begin
        fault     = in_mem_addr[0];
        st_mask   = DATA_W'(64'hFFFF);
        strb_base = STRB_W'(8'h03);
      end
      2'd2: begin
        fault     = |in_mem_addr[1:0];
        st_mask   = DATA_W'(64'hFFFF_FFFF);
        strb_base = STRB_W'(8'h0F);
      end
      default: begin
        fault     = (DATA_W == 32) | (|in_mem_addr[2:0]);
        st_mask   = '1;
        strb_base = '1;
      end
    endcase
    st_data_sh = (in_stor_data & st_mask) << {in_off, 3'b000};
    st_strb_sh = strb_base << in_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = mem_go ? REQ : DONE;
      REQ:  if (bus.bus_req_ready) next_state = WAIT;
      WAIT: if (bus.bus_rsp_valid) next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready          = (state == IDLE);
    bus.bus_req_valid = (state == REQ);
    out_valid         = (state == DONE);
  end

  // Right-align the addressed lane, then fill above the access size
  always_comb begin
    shifted = bus.bus_rdata >> {ld_off, 3'b000};
    ld_mask = '1;
    ld_sbit = 1'b0;
    case (ld_size)
      2'd0: begin ld_mask = DATA_W'(64'hFF);        ld_sbit = shifted[7];  end
      2'd1: begin ld_mask = DATA_W'(64'hFFFF);      ld_sbit = shifted[15]; end
      2'd2: begin ld_mask = DATA_W'(64'hFFFF_FFFF); ld_sbit = shifted[31]; end
      default: begin ld_mask = '1; ld_sbit = 1'b0; end
    endcase
    ld_val = (shifted & ld_mask) | ({DATA_W{~ld_uns & ld_sbit}} & ~ld_mask);
  end

  // Bus fields are only reloaded for accesses that actually go to the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wr_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ld_size    <= 2'd0;
      ld_uns     <= 1'b0;
      ld_off     <= '0;
      out_w_ena  <= 1'b0;
      out_w_addr <= '0;
      out_w_data <= '0;
      out_exc    <= 1'b0;
      out_pc     <= '0;
      out_instr  <= '0;
    end else if (accept) begin
      if (mem_go) begin
        req_wr_q <= in_mem_wr;
        addr_q   <= {in_mem_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wdata_q  <= in_mem_wr ? st_data_sh : '0;
        wstrb_q  <= in_mem_wr ? st_strb_sh : '0;
      end
      ld_size    <= in_mem_op[1:0];
      ld_uns     <= in_mem_op[2];
      ld_off     <= in_off;
      out_w_ena  <= in_w_ena & ~(in_mem_ena & (fault | in_mem_wr));
      out_w_addr <= in_w_addr;
      out_w_data <= (mem_go & in_mem_wr) ? '0 : in_w_data;
      out_exc    <= in_mem_ena & fault;
      out_pc     <= in_pc;
      out_instr  <= in_instr;
    end else if (state == WAIT && bus.bus_rsp_valid && !req_wr_q) begin
      out_w_data <= ld_val;
    end
  end

  assign bus.bus_req_wr = req_wr_q;
  assign bus.bus_addr   = addr_q;
  assign bus.bus_wdata  = wdata_q;
  assign bus.bus_wstrb  = wstrb_q;
endmodule

// File: tb/tb_ysyx_22040931_lsu.sv
// Directed bench for the load/store unit: a 64-bit instance for the main behaviour
// and a 32-bit instance for the width-dependent size-D fault and lane placement.
module tb_ysyx_22040931_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid32 = 1'b0;
  logic        in_w_ena = 1'b0;
  logic [4:0]  in_w_addr = '0;
  logic [63:0] in_w_data = '0;
  logic        in_mem_ena = 1'b0;
  logic        in_mem_wr = 1'b0;
  logic [2:0]  in_mem_op = '0;
  logic [31:0] in_mem_addr = '0;
  logic [63:0] in_stor_data = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_w_ena, out_exc;
  logic [4:0]  out_w_addr;
  logic [63:0] out_w_data;
  logic [31:0] out_pc, out_instr;

  logic        in_ready32, out_valid32, out_w_ena32, out_exc32;
  logic [4:0]  out_w_addr32;
  logic [31:0] out_w_data32;
  logic [31:0] out_pc32, out_instr32;

  int checks = 0;
  int errors = 0;

  ysyx_22040931_lsu_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();
  ysyx_22040931_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();

  ysyx_22040931_lsu #(.DATA_W(64), .ADDR_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_w_ena(in_w_ena), .in_w_addr(in_w_addr), .in_w_data(in_w_data),
    .in_mem_ena(in_mem_ena), .in_mem_wr(in_mem_wr), .in_mem_op(in_mem_op),
    .in_mem_addr(in_mem_addr), .in_stor_data(in_stor_data),
    .in_pc(in_pc), .in_instr(in_instr),
    .bus(bus64.master),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_w_ena(out_w_ena), .out_w_addr(out_w_addr), .out_w_data(out_w_data),
    .out_exc(out_exc), .out_pc(out_pc), .out_instr(out_instr)
  );

  ysyx_22040931_lsu #(.DATA_W(32), .ADDR_W(32), .REG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .in_w_ena(in_w_ena), .in_w_addr(in_w_addr), .in_w_data(in_w_data[31:0]),
    .in_mem_ena(in_mem_ena), .in_mem_wr(in_mem_wr), .in_mem_op(in_mem_op),
    .in_mem_addr(in_mem_addr), .in_stor_data(in_stor_data[31:0]),
    .in_pc(in_pc), .in_instr(in_instr),
    .bus(bus32.master),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_w_ena(out_w_ena32), .out_w_addr(out_w_addr32), .out_w_data(out_w_data32),
    .out_exc(out_exc32), .out_pc(out_pc32), .out_instr(out_instr32)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for exactly one clock edge to the selected instance
  task automatic applyStimulus(input bit to32, input logic mem_ena, input logic wr,
                               input logic [2:0] op, input logic [31:0] addr,
                               input logic [63:0] stor, input logic w_ena,
                               input logic [4:0] w_addr, input logic [63:0] w_data);
    checkOutput("in_ready_before_issue", to32 ? in_ready32 : in_ready, 1'b1);
    in_mem_ena   = mem_ena;
    in_mem_wr    = wr;
    in_mem_op    = op;
    in_mem_addr  = addr;
    in_stor_data = stor;
    in_w_ena     = w_ena;
    in_w_addr    = w_addr;
    in_w_data    = w_data;
    in_pc        = 32'h8000_0100;
    in_instr     = 32'h0000_3003;
    in_valid     = !to32;
    in_valid32   = to32;
    step();
    in_valid     = 1'b0;
    in_valid32   = 1'b0;
  endtask

  // Request accepted on the first edge, response on the next one
  task automatic runBus(input logic [63:0] rdata);
    bus64.bus_req_ready = 1'b1;
    step();
    bus64.bus_req_ready = 1'b0;
    bus64.bus_rsp_valid = 1'b1;
    bus64.bus_rdata     = rdata;
    step();
    bus64.bus_rsp_valid = 1'b0;
  endtask

  initial begin
    bus64.bus_req_ready = 1'b0;
    bus64.bus_rsp_valid = 1'b0;
    bus64.bus_rdata     = '0;
    bus32.bus_req_ready = 1'b0;
    bus32.bus_rsp_valid = 1'b0;
    bus32.bus_rdata     = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_bus_req_valid", bus64.bus_req_valid, 1'b0);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_w_data", out_w_data, 64'h0);
    checkOutput("rst_bus_wstrb", bus64.bus_wstrb, 8'h0);
    checkOutput("rst_bus_addr", bus64.bus_addr, 32'h0);
    checkOutput("rst_out_exc", out_exc, 1'b0);
    rst_n = 1'b1;
    step();

    $display("[TB] pass-through");
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 64'h0, 1'b1, 5'd5, 64'h1234);
    checkOutput("pt_out_valid", out_valid, 1'b1);
    checkOutput("pt_out_w_data", out_w_data, 64'h1234);
    checkOutput("pt_out_w_ena", out_w_ena, 1'b1);
    checkOutput("pt_out_w_addr", out_w_addr, 5'd5);
    checkOutput("pt_out_pc", out_pc, 32'h8000_0100);
    checkOutput("pt_bus_req_valid", bus64.bus_req_valid, 1'b0);
    checkOutput("pt_in_ready", in_ready, 1'b0);
    step();
    checkOutput("pt_retire_in_ready", in_ready, 1'b1);
    checkOutput("pt_retire_out_valid", out_valid, 1'b0);

    $display("[TB] store byte");
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h8003, 64'hAB, 1'b1, 5'd1, 64'h77);
    checkOutput("sb_req_valid", bus64.bus_req_valid, 1'b1);
    checkOutput("sb_req_wr", bus64.bus_req_wr, 1'b1);
    checkOutput("sb_addr", bus64.bus_addr, 32'h8000);
    checkOutput("sb_wstrb", bus64.bus_wstrb, 8'h08);
    checkOutput("sb_wdata", bus64.bus_wdata, 64'h0000_0000_AB00_0000);
    runBus(64'h0);
    checkOutput("sb_out_valid", out_valid, 1'b1);
    checkOutput("sb_out_w_ena", out_w_ena, 1'b0);
    checkOutput("sb_out_w_data", out_w_data, 64'h0);
    step();

    $display("[TB] store half and double");
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd1, 32'h800A, 64'hFFFF_BEEF, 1'b0, 5'd0, 64'h0);
    checkOutput("sh_wstrb", bus64.bus_wstrb, 8'h0C);
    checkOutput("sh_wdata", bus64.bus_wdata, 64'h0000_0000_BEEF_0000);
    checkOutput("sh_addr", bus64.bus_addr, 32'h8008);
    runBus(64'h0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 32'h8008, 64'h1122_3344_5566_7788, 1'b0, 5'd0, 64'h0);
    checkOutput("sd_wstrb", bus64.bus_wstrb, 8'hFF);
    checkOutput("sd_wdata", bus64.bus_wdata, 64'h1122_3344_5566_7788);
    runBus(64'h0);
    step();

    $display("[TB] loads");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd1, 32'h8006, 64'h0, 1'b1, 5'd7, 64'h0);
    checkOutput("lh_req_wr", bus64.bus_req_wr, 1'b0);
    checkOutput("lh_addr", bus64.bus_addr, 32'h8000);
    runBus(64'h8001_0000_0000_0000);
    checkOutput("lh_signed", out_w_data, 64'hFFFF_FFFF_FFFF_8001);
    checkOutput("lh_w_ena", out_w_ena, 1'b1);
    checkOutput("lh_w_addr", out_w_addr, 5'd7);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd5, 32'h8006, 64'h0, 1'b1, 5'd7, 64'h0);
    runBus(64'h8001_0000_0000_0000);
    checkOutput("lhu_unsigned", out_w_data, 64'h8001);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 32'h8004, 64'h0, 1'b1, 5'd9, 64'h0);
    runBus(64'h89AB_CDEF_0123_4567);
    checkOutput("lw_signed", out_w_data, 64'hFFFF_FFFF_89AB_CDEF);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd4, 32'h8001, 64'h0, 1'b1, 5'd9, 64'h0);
    runBus(64'h0000_0000_0000_F600);
    checkOutput("lbu_unsigned", out_w_data, 64'hF6);
    step();

    $display("[TB] misaligned word");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 32'h8002, 64'h0, 1'b1, 5'd3, 64'h55);
    checkOutput("mis_out_valid", out_valid, 1'b1);
    checkOutput("mis_out_exc", out_exc, 1'b1);
    checkOutput("mis_out_w_ena", out_w_ena, 1'b0);
    checkOutput("mis_out_w_data", out_w_data, 64'h55);
    checkOutput("mis_req_valid", bus64.bus_req_valid, 1'b0);
    step();
    checkOutput("mis_req_valid_after", bus64.bus_req_valid, 1'b0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 32'h8010, 64'h0, 1'b1, 5'd4, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("bp_req_valid_hold", bus64.bus_req_valid, 1'b1);
      checkOutput("bp_addr_hold", bus64.bus_addr, 32'h8010);
      checkOutput("bp_in_ready_req", in_ready, 1'b0);
    end
    bus64.bus_req_ready = 1'b1;
    step();
    bus64.bus_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("bp_wait_req_valid", bus64.bus_req_valid, 1'b0);
      checkOutput("bp_wait_out_valid", out_valid, 1'b0);
      checkOutput("bp_in_ready_wait", in_ready, 1'b0);
      step();
    end
    bus64.bus_rsp_valid = 1'b1;
    bus64.bus_rdata     = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    bus64.bus_rsp_valid = 1'b0;
    bus64.bus_rdata     = 64'h0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_out_valid_hold", out_valid, 1'b1);
      checkOutput("bp_out_data_hold", out_w_data, 64'hDEAD_BEEF_CAFE_F00D);
      checkOutput("bp_in_ready_done", in_ready, 1'b0);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    checkOutput("bp_release_in_ready", in_ready, 1'b1);
    checkOutput("bp_release_out_valid", out_valid, 1'b0);

    bus64.bus_rsp_valid = 1'b1;
    step();
    bus64.bus_rsp_valid = 1'b0;
    checkOutput("stray_rsp_out_valid", out_valid, 1'b0);
    checkOutput("stray_rsp_in_ready", in_ready, 1'b1);

    $display("[TB] reset during wait");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 32'h8020, 64'h0, 1'b1, 5'd6, 64'h0);
    bus64.bus_req_ready = 1'b1;
    step();
    bus64.bus_req_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    checkOutput("rstw_in_ready", in_ready, 1'b1);
    checkOutput("rstw_out_valid", out_valid, 1'b0);
    checkOutput("rstw_req_valid", bus64.bus_req_valid, 1'b0);
    rst_n = 1'b1;
    bus64.bus_rsp_valid = 1'b1;
    bus64.bus_rdata     = 64'h1111_2222_3333_4444;
    step();
    bus64.bus_rsp_valid = 1'b0;
    checkOutput("rstw_stale_out_valid", out_valid, 1'b0);
    checkOutput("rstw_stale_in_ready", in_ready, 1'b1);
    checkOutput("rstw_stale_w_data", out_w_data, 64'h0);

    $display("[TB] 32-bit instance");
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 32'h8000, 64'h0, 1'b1, 5'd2, 64'h99);
    checkOutput("w32_d_out_valid", out_valid32, 1'b1);
    checkOutput("w32_d_exc", out_exc32, 1'b1);
    checkOutput("w32_d_w_ena", out_w_ena32, 1'b0);
    checkOutput("w32_d_req_valid", bus32.bus_req_valid, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 32'h8003, 64'hAB, 1'b0, 5'd0, 64'h0);
    checkOutput("w32_sb_addr", bus32.bus_addr, 32'h8000);
    checkOutput("w32_sb_wstrb", bus32.bus_wstrb, 4'h8);
    checkOutput("w32_sb_wdata", bus32.bus_wdata, 32'hAB00_0000);
    bus32.bus_req_ready = 1'b1;
    step();
    bus32.bus_req_ready = 1'b0;
    bus32.bus_rsp_valid = 1'b1;
    step();
    bus32.bus_rsp_valid = 1'b0;
    checkOutput("w32_sb_out_valid", out_valid32, 1'b1);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 32'h8004, 64'h0, 1'b1, 5'd8, 64'h0);
    bus32.bus_req_ready = 1'b1;
    step();
    bus32.bus_req_ready = 1'b0;
    bus32.bus_rsp_valid = 1'b1;
    bus32.bus_rdata     = 32'h8000_0001;
    step();
    bus32.bus_rsp_valid = 1'b0;
    checkOutput("w32_lw_data", out_w_data32, 32'h8000_0001);
    checkOutput("w32_lw_w_ena", out_w_ena32, 1'b1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
